led_pattern_ctrl: RTL and testbench
===================================

// Module: led_pattern_ctrl
// PURPOSE
//  Single-clock LED pattern sequencer driving the board LEDs from two slide switches.
//  - Replaces the divided-clock scheme: a prescaler produces a 1-cycle tick enable,
//    so all logic runs on clk.
//  - Debounces sw, selects one of four patterns, and steps the pattern once per tick.
//  - Sits directly under the board top, between board pins and the LEDs.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per pattern step (>=2)
//  DB_CYCLES  1_000_000   cycles a synced sw value must hold before acceptance (>=1)
//  LED_W      4           LED count (>=2)
// PORTS
//  clk    in   1      system clock
//  rst    in   1      asynchronous, active-low reset
//  sw     in   2      raw slide switches, asynchronous to clk
//  led    out  LED_W  pattern output, registered
//  mode   out  2      debounced mode currently applied
//  tick   out  1      one-cycle step strobe, registered
// BEHAVIOUR
//  - Reset (rst=0): led=0, mode=0, tick=0, state=IDLE, prescaler=0, direction=left,
//    debounce counters=0, sync flops=0.
//  - Input path:
//    - 2-flop synchronizer per sw bit.
//    - Debounce on the 2-bit vector: the stable value updates only after the synced value
//      differs from it for DB_CYCLES consecutive cycles.
//    - Any mismatch glitch clears the count.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps to 0.
//    - tick=1 for exactly the cycle after the count equals TICK_DIV-1.
//    - Counter width is $clog2(TICK_DIV).
//  - Modes: 00 ROT_L, 01 ROT_R, 10 COUNT, 11 PINGPONG.
//  - Seeds:
//    - ROT_L: 0..01
//    - ROT_R: 10..0
//    - COUNT: 0
//    - PINGPONG: 0..01 with dir=left
//  - FSM states IDLE, LOAD, RUN:
//    - IDLE -> LOAD unconditionally on the first clk after reset release.
//    - LOAD (1 cycle): mode <= debounced value; led <= seed(mode); prescaler <= 0; -> RUN.
//    - RUN, debounced value != mode: -> LOAD. A tick in the same cycle is dropped.
//    - RUN on tick:
//      - ROT_L rotates left; ROT_R rotates right.
//      - COUNT: led+1 mod 2^LED_W, wraps all-ones -> 0.
//      - PINGPONG: shift in dir. Reaching bit LED_W-1 sets dir=right; reaching bit 0 sets
//        dir=left. There is no wrap.
//  - Latency:
//    - Debounced change to new seed on led: 2 cycles (RUN->LOAD, LOAD->led update).
//    - First step after LOAD occurs TICK_DIV cycles later.
//  - Reset asserted mid-pattern returns everything to reset values immediately
//    (asynchronous).
// CONFIGURATION
//  LED_CTRL_PAUSE_EN
//  - Defined: adds input port `pause` (1 bit, async, passes the same sync + debounce path).
//    - While the debounced pause=1 in RUN: prescaler holds, tick=0, led frozen.
//    - Mode changes still force LOAD.
//    - On release, counting resumes from the held prescaler value.
//  - Undefined: no pause port; free-running behaviour as above.
// STRUCTURE
//  - Package led_ctrl_pkg:
//    - mode_e (ROT_L, ROT_R, COUNT, PINGPONG)
//    - state_e (IDLE, LOAD, RUN)
//    - function seed(mode_e, LED_W)
//  - Sub-module sw_debounce (parameters W, DB_CYCLES):
//    - contains synchronizer + debounce counter
//    - instanced once for sw and, with LED_CTRL_PAUSE_EN, once for pause
// TESTING (bench params TICK_DIV=4, DB_CYCLES=3, LED_W=4)
//  1. Reset release, sw=00 -> led=0001 two cycles later; then tick every 4 cycles;
//     led 0010,0100,1000,0001.
//  2. sw 00->10 held -> after sync+3 cycles, LOAD; led=0000, then 0001,0010; after 1111,
//     next tick gives 0000.
//  3. sw=11 -> led 0001,0010,0100,1000,0100,0010,0001,0010 (bounce, no wrap).
//  4. sw bit pulsed for 2 cycles only -> mode and led unchanged, no LOAD.
//  5. Debounced change lands on a tick cycle -> led=new seed, no step that cycle,
//     next step 4 cycles after LOAD.
//  6. rst low mid-run (async, between edges) -> led=0, tick=0 at once; with
//     LED_CTRL_PAUSE_EN: pause=1 freezes led, pause=0 resumes stepping.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and seed helper for the LED pattern sequencer.
package led_ctrl_pkg;

   localparam int SEED_W = 32;

   typedef enum logic [1:0] {
      ROT_L    = 2'b00,
      ROT_R    = 2'b01,
      COUNT    = 2'b10,
      PINGPONG = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Caller truncates to its LED width; only the low led_w bits are meaningful.
   function automatic logic [SEED_W-1:0] seed(input mode_e m, input int led_w);
      logic [SEED_W-1:0] s;
      s = '0;
      case (m)
         ROT_L, PINGPONG: s = SEED_W'(1);
         ROT_R:           s = SEED_W'(1) << (led_w - 1);
         default:         s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer per bit followed by a whole-vector debounce counter:
// the output adopts the synced value after it has differed for DB_CYCLES cycles.
module sw_debounce #(
   parameter int W         = 2,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [W-1:0]  sync_w;
   logic [W-1:0]  stable_reg, stable_next;
   logic [CW-1:0] cnt_reg, cnt_next;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_sync
         logic meta_reg, sync_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= din[gi];
               sync_reg <= meta_reg;
            end
         end
         assign sync_w[gi] = sync_reg;
      end
   endgenerate

   // A cycle where the synced value matches the stable one restarts the count.
   always_comb begin
      stable_next = stable_reg;
      cnt_next    = '0;
      if (sync_w != stable_reg) begin
         if (cnt_reg == CNT_LAST) stable_next = sync_w;
         else                     cnt_next    = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         stable_reg <= stable_next;
         cnt_reg    <= cnt_next;
      end
   end

   assign dout = stable_reg;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Single-clock LED pattern sequencer: debounced 2-bit mode select, prescaled step enable.
// Optional LED_CTRL_PAUSE_EN adds a debounced pause input that freezes stepping in RUN.
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int DB_CYCLES = 1_000_000,
   parameter int LED_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       sw,
`ifdef LED_CTRL_PAUSE_EN
   input  logic             pause,
`endif
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic             tick
);

   localparam int            PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   state_e           state_reg, state_next;
   mode_e            mode_reg, mode_next;
   mode_e            sw_mode;
   logic [LED_W-1:0] led_reg, led_next, step_val;
   logic [PW-1:0]    pre_reg, pre_next;
   logic             dir_right_reg, dir_right_next, dir_after;
   logic             tick_reg, tick_next;
   logic [1:0]       sw_db;
   logic             pause_db;

   sw_debounce #(.W(2), .DB_CYCLES(DB_CYCLES)) u_sw_db (
      .clk  (clk),
      .rst  (rst),
      .din  (sw),
      .dout (sw_db)
   );

`ifdef LED_CTRL_PAUSE_EN
   logic [0:0] pause_vec;
   sw_debounce #(.W(1), .DB_CYCLES(DB_CYCLES)) u_pause_db (
      .clk  (clk),
      .rst  (rst),
      .din  (pause),
      .dout (pause_vec)
   );
   assign pause_db = pause_vec[0];
`else
   assign pause_db = 1'b0;
`endif

   assign sw_mode = mode_e'(sw_db);

   // Next pattern value for the applied mode; ping-pong flips direction on reaching an end.
   always_comb begin
      step_val  = led_reg;
      dir_after = dir_right_reg;
      case (mode_reg)
         ROT_L:   step_val = {led_reg[LED_W-2:0], led_reg[LED_W-1]};
         ROT_R:   step_val = {led_reg[0], led_reg[LED_W-1:1]};
         COUNT:   step_val = led_reg + 1'b1;
         default: begin
            if (dir_right_reg) begin
               step_val = led_reg >> 1;
               if (step_val[0]) dir_after = 1'b0;
            end else begin
               step_val = led_reg << 1;
               if (step_val[LED_W-1]) dir_after = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      mode_next      = mode_reg;
      led_next       = led_reg;
      pre_next       = pre_reg;
      dir_right_next = dir_right_reg;
      tick_next      = 1'b0;
      case (state_reg)
         IDLE: state_next = LOAD;
         LOAD: begin
            mode_next      = sw_mode;
            led_next       = LED_W'(seed(sw_mode, LED_W));
            pre_next       = '0;
            dir_right_next = 1'b0;
            state_next     = RUN;
         end
         RUN: begin
            // A pending mode change wins over a coincident step.
            if (sw_mode != mode_reg) begin
               state_next = LOAD;
            end else if (!pause_db) begin
               if (pre_reg == PRE_LAST) begin
                  pre_next       = '0;
                  tick_next      = 1'b1;
                  led_next       = step_val;
                  dir_right_next = dir_after;
               end else begin
                  pre_next = pre_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         mode_reg      <= ROT_L;
         led_reg       <= '0;
         pre_reg       <= '0;
         dir_right_reg <= 1'b0;
         tick_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mode_reg      <= mode_next;
         led_reg       <= led_next;
         pre_reg       <= pre_next;
         dir_right_reg <= dir_right_next;
         tick_reg      <= tick_next;
      end
   end

   assign led  = led_reg;
   assign mode = mode_reg;
   assign tick = tick_reg;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: a per-cycle reference model queues expected
// outputs, a monitor on the falling edge pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

   localparam int TICK_DIV  = 4;
   localparam int DB_CYCLES = 3;
   localparam int LED_W     = 4;
   localparam int HIST      = 2 + DB_CYCLES;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [1:0]       sw  = 2'b00;
`ifdef LED_CTRL_PAUSE_EN
   logic             pause = 1'b0;
`endif
   logic [LED_W-1:0] led;
   logic [1:0]       mode;
   logic             tick;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [LED_W-1:0] led;
      logic [1:0]       mode;
      logic             tick;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   led_pattern_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .DB_CYCLES (DB_CYCLES),
      .LED_W     (LED_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw),
`ifdef LED_CTRL_PAUSE_EN
      .pause(pause),
`endif
      .led  (led),
      .mode (mode),
      .tick (tick)
   );

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // k-th element of each pattern, straight from the pattern definitions.
   function automatic logic [LED_W-1:0] pattern(input int m, input int kk);
      int p;
      case (m)
         0: return LED_W'(1 << (kk % LED_W));
         1: return LED_W'((1 << (LED_W - 1)) >> (kk % LED_W));
         2: return LED_W'(kk % (1 << LED_W));
         default: begin
            p = kk % (2 * (LED_W - 1));
            if (p > LED_W - 1) p = 2 * (LED_W - 1) - p;
            return LED_W'(1 << p);
         end
      endcase
   endfunction

   // hist[0] is this edge's raw sample; hist[2..] are values seen by the debouncer.
   function automatic int settle(input int hist[$], input int stable);
      for (int i = 2; i < HIST; i++)
         if (hist[i] == stable) return stable;
      return hist[2];
   endfunction

   int               sw_hist[$];
   int               p_hist[$];
   int               stable_sw, stable_p, ph, m_mode, k, since;
   logic [LED_W-1:0] m_led;
   logic             m_tick;

   // ph: 0 = waiting after reset, 1 = load pending, 2 = running
   always @(posedge clk) begin
      exp_t e;
      if (!rst) begin
         sw_hist.delete();
         p_hist.delete();
         for (int i = 0; i < HIST; i++) begin
            sw_hist.push_back(0);
            p_hist.push_back(0);
         end
         stable_sw = 0; stable_p = 0; ph = 0; m_mode = 0; k = 0; since = 0;
         m_led = '0; m_tick = 1'b0;
      end else begin
         sw_hist.push_front(int'(sw));
         void'(sw_hist.pop_back());
`ifdef LED_CTRL_PAUSE_EN
         p_hist.push_front(int'(pause));
`else
         p_hist.push_front(0);
`endif
         void'(p_hist.pop_back());
         m_tick = 1'b0;
         case (ph)
            0: ph = 1;
            1: begin
               m_mode = stable_sw; k = 0; since = 0; ph = 2;
            end
            default: begin
               if (stable_sw != m_mode) ph = 1;
               else if (stable_p == 0) begin
                  since++;
                  if (since % TICK_DIV == 0) begin
                     k++;
                     m_tick = 1'b1;
                  end
               end
            end
         endcase
         if (ph == 2) m_led = pattern(m_mode, k);
         stable_sw = settle(sw_hist, stable_sw);
         stable_p  = settle(p_hist, stable_p);
      end
      e.led  = m_led;
      e.mode = 2'(m_mode);
      e.tick = m_tick;
      exp_q.push_back(e);
   end

   // Asynchronous reset between edges overrides the expectation for the current cycle.
   always @(negedge rst) begin
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '{'0, 2'b00, 1'b0};
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("queue_underflow", 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk("led", int'(led), int'(e.led));
         chk("mode", int'(mode), int'(e.mode));
         chk("tick", int'(tick), int'(e.tick));
      end
   end

   task automatic hold(input logic [1:0] v, input int n);
      @(negedge clk);
      sw = v;
      $display("sw=%b hold=%0d cycles", v, n);
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      sw  = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      $display("reset released, sw=00");
      repeat (24) @(negedge clk);

      hold(2'b10, 80);          // count, including 1111 -> 0000 wrap
      hold(2'b11, 40);          // ping-pong bounce
      hold(2'b01, 2);           // short glitch back to a different mode
      hold(2'b11, 20);
      hold(2'b10, 1);
      hold(2'b11, 20);

      for (int j = 0; j < 8; j++)   // mode changes at every prescaler phase
         hold(2'(j % 4), 21 + (j % 4));

      for (int j = 0; j < 60; j++)
         hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 25)));

`ifdef LED_CTRL_PAUSE_EN
      hold(2'b00, 20);
      @(negedge clk);
      pause = 1'b1;
      $display("pause=1");
      repeat (30) @(negedge clk);
      pause = 1'b0;
      $display("pause=0");
      repeat (30) @(negedge clk);
      @(negedge clk);
      pause = 1'b1;
      repeat (2) @(negedge clk);
      pause = 1'b0;
      $display("pause glitch");
      repeat (20) @(negedge clk);
`endif

      hold(2'b00, 30);
      @(posedge clk);
      #2 rst = 1'b0;
      $display("async reset mid-run");
      #1;
      chk("async_led", int'(led), 0);
      chk("async_tick", int'(tick), 0);
      chk("async_mode", int'(mode), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      hold(2'b01, 40);

      repeat (2) @(negedge clk);
      #1;
      chk("queue_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
